// File: rtl/spi_sysbus_pkg.sv
// Shared constants for the SB_SPI system-bus sequencer: register addresses,
// status-register bit positions and the sequencer state encoding.
package spi_sysbus_pkg;

  // SB_SPI register addresses (low byte of SBADRI)
  localparam logic [7:0] AdrCr0  = 8'h08;
  localparam logic [7:0] AdrCr1  = 8'h09;
  localparam logic [7:0] AdrCr2  = 8'h0A;
  localparam logic [7:0] AdrBr   = 8'h0B;
  localparam logic [7:0] AdrSr   = 8'h0C;
  localparam logic [7:0] AdrTxdr = 8'h0D;
  localparam logic [7:0] AdrRxdr = 8'h0E;
  localparam logic [7:0] AdrCsr  = 8'h0F;

  // SPISR bit indices
  localparam int unsigned SrRrdy = 3;
  localparam int unsigned SrTrdy = 4;

  typedef enum logic [2:0] {
    StWCr0,
    StWCr1,
    StWCr2,
    StWBr,
    StWCsr,
    StPoll,
    StRdRx,
    StWrTx
  } state_e;

endpackage

// File: rtl/spi_sysbus_ctrl_sb_access.sv
// Single-access engine for the SB_SPI system bus.
// Latches rw/adr/dati when start is accepted, raises the strobe and holds
// everything stable until ack. The strobe drops on the cycle after ack, which
// guarantees an idle cycle between accesses; a new access is never started
// while ack is still high.
// Optional: SPI_SYSBUS_TIMEOUT_EN adds an ack watchdog (timeout pulse, strobe
// dropped) after TIMEOUT_CYCLES strobe cycles without ack.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, rw, adr, dati  access request (taken when ready)
//   ready                 engine idle and bus free; start is accepted now
//   done                  ack cycle of the current access
//   timeout               watchdog expiry (always 0 without the macro)
//   rdata                 read data, valid while done
//   sb_*                  SB_SPI system-bus pins
module spi_sysbus_ctrl_sb_access
`ifdef SPI_SYSBUS_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] adr,
  input  logic [7:0] dati,
  output logic       ready,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rdata,
  output logic       sb_stb,
  output logic       sb_rw,
  output logic [7:0] sb_adr,
  output logic [7:0] sb_dati,
  input  logic [7:0] sb_dato,
  input  logic       sb_ack
);

  logic       stb_q, stb_d;
  logic       rw_q, rw_d;
  logic [7:0] adr_q, adr_d;
  logic [7:0] dati_q, dati_d;

  assign ready = ~stb_q & ~sb_ack;
  assign done  = stb_q & sb_ack;
  assign rdata = sb_dato;

`ifdef SPI_SYSBUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign timeout = stb_q & ~sb_ack & (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = 8'd0;
    if (stb_q && !sb_ack && !timeout) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    stb_d  = stb_q;
    rw_d   = rw_q;
    adr_d  = adr_q;
    dati_d = dati_q;
    if (ready && start) begin
      stb_d  = 1'b1;
      rw_d   = rw;
      adr_d  = adr;
      dati_d = dati;
    end else if (done || timeout) begin
      stb_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q  <= 1'b0;
      rw_q   <= 1'b0;
      adr_q  <= 8'd0;
      dati_q <= 8'd0;
    end else begin
      stb_q  <= stb_d;
      rw_q   <= rw_d;
      adr_q  <= adr_d;
      dati_q <= dati_d;
    end
  end

  assign sb_stb  = stb_q;
  assign sb_rw   = rw_q;
  assign sb_adr  = adr_q;
  assign sb_dati = dati_q;

endmodule

// File: rtl/spi_sysbus_ctrl.sv
// Sequencer for the SB_SPI hard IP system bus in SPI-slave mode.
// After reset it writes CR0, CR1, CR2, BR and CSR, then polls SR. Received
// bytes (RRDY) are read from RXDR onto the rx valid/ready stream; bytes from
// the tx stream are written to TXDR when TRDY is set. RX wins when both are
// ready. A reinit pulse is latched and reruns the init writes after the
// current access completes.
// Optional: SPI_SYSBUS_TIMEOUT_EN enables the ack watchdog and the sticky err
// flag; without it err is tied low.
// Ports:
//   clk, rst_n                   clock (= SBCLKI), async active-low reset
//   reinit                       re-run the init sequence
//   sb_stb/sb_rw/sb_adr/sb_dati  system-bus request to SB_SPI
//   sb_dato/sb_ack               system-bus response from SB_SPI
//   rx_data/rx_valid/rx_ready    received byte stream
//   tx_data/tx_valid/tx_ready    transmit byte stream (tx_ready = written pulse)
//   init_done, status, err       init complete, last SPISR, ack timeout seen
module spi_sysbus_ctrl
  import spi_sysbus_pkg::*;
#(
  parameter logic [7:0] CR0_VAL = 8'h00,
  parameter logic [7:0] CR1_VAL = 8'h80,
  parameter logic [7:0] CR2_VAL = 8'h01,
  parameter logic [7:0] BR_VAL  = 8'h00,
  parameter logic [7:0] CSR_VAL = 8'h00
`ifdef SPI_SYSBUS_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reinit,
  output logic       sb_stb,
  output logic       sb_rw,
  output logic [7:0] sb_adr,
  output logic [7:0] sb_dati,
  input  logic [7:0] sb_dato,
  input  logic       sb_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       init_done,
  output logic [7:0] status,
  output logic       err
);

  state_e     state_q, state_d;
  logic       init_done_q, init_done_d;
  logic       reinit_q, reinit_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       tx_ready_q, tx_ready_d;
  logic [7:0] status_q, status_d;

  logic       acc_rw;
  logic [7:0] acc_adr;
  logic [7:0] acc_dati;
  logic       acc_ready;
  logic       acc_done;
  logic       acc_timeout;
  logic [7:0] acc_rdata;

  // Every state performs exactly one access, so a request is always pending;
  // the engine decides when it may actually start.
  spi_sysbus_ctrl_sb_access
`ifdef SPI_SYSBUS_TIMEOUT_EN
  #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  )
`endif
  u_access (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (1'b1),
    .rw      (acc_rw),
    .adr     (acc_adr),
    .dati    (acc_dati),
    .ready   (acc_ready),
    .done    (acc_done),
    .timeout (acc_timeout),
    .rdata   (acc_rdata),
    .sb_stb  (sb_stb),
    .sb_rw   (sb_rw),
    .sb_adr  (sb_adr),
    .sb_dati (sb_dati),
    .sb_dato (sb_dato),
    .sb_ack  (sb_ack)
  );

  // Access decode per state
  always_comb begin
    acc_rw   = 1'b0;
    acc_adr  = AdrSr;
    acc_dati = 8'h00;
    unique case (state_q)
      StWCr0: begin acc_rw = 1'b1; acc_adr = AdrCr0;  acc_dati = CR0_VAL; end
      StWCr1: begin acc_rw = 1'b1; acc_adr = AdrCr1;  acc_dati = CR1_VAL; end
      StWCr2: begin acc_rw = 1'b1; acc_adr = AdrCr2;  acc_dati = CR2_VAL; end
      StWBr:  begin acc_rw = 1'b1; acc_adr = AdrBr;   acc_dati = BR_VAL;  end
      StWCsr: begin acc_rw = 1'b1; acc_adr = AdrCsr;  acc_dati = CSR_VAL; end
      StPoll: begin acc_rw = 1'b0; acc_adr = AdrSr;                       end
      StRdRx: begin acc_rw = 1'b0; acc_adr = AdrRxdr;                     end
      StWrTx: begin acc_rw = 1'b1; acc_adr = AdrTxdr; acc_dati = tx_data; end
      default: ;
    endcase
  end

  // Next state and stream handshakes
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    reinit_d    = reinit_q | reinit;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    tx_ready_d  = 1'b0;
    status_d    = status_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (acc_timeout) begin
      state_d     = StWCr0;
      init_done_d = 1'b0;
      reinit_d    = 1'b0;
    end else if (acc_done) begin
      unique case (state_q)
        StWCr0: state_d = StWCr1;
        StWCr1: state_d = StWCr2;
        StWCr2: state_d = StWBr;
        StWBr:  state_d = StWCsr;
        StWCsr: begin
          state_d     = StPoll;
          init_done_d = 1'b1;
        end
        StPoll: begin
          status_d = acc_rdata;
          // A held rx byte blocks RXDR reads; TX may still proceed
          if (acc_rdata[SrRrdy] && !rx_valid_q) begin
            state_d = StRdRx;
          end else if (acc_rdata[SrTrdy] && tx_valid) begin
            state_d = StWrTx;
          end
        end
        StRdRx: begin
          rx_data_d  = acc_rdata;
          rx_valid_d = 1'b1;
          state_d    = StPoll;
        end
        StWrTx: begin
          tx_ready_d = 1'b1;
          state_d    = StPoll;
        end
        default: state_d = StWCr0;
      endcase
      if (reinit_q || reinit) begin
        state_d     = StWCr0;
        init_done_d = 1'b0;
      end
      reinit_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWCr0;
      init_done_q <= 1'b0;
      reinit_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      tx_ready_q  <= 1'b0;
      status_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      reinit_q    <= reinit_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      tx_ready_q  <= tx_ready_d;
      status_q    <= status_d;
    end
  end

`ifdef SPI_SYSBUS_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (acc_timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_ready  = tx_ready_q;
  assign init_done = init_done_q;
  assign status    = status_q;

endmodule

// File: tb/tb_spi_sysbus_ctrl.sv
// Directed bench for spi_sysbus_ctrl with a small SB_SPI bus model.
module tb_spi_sysbus_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reinit = 1'b0;
  logic       sb_stb, sb_rw;
  logic [7:0] sb_adr, sb_dati, sb_dato;
  logic       sb_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, init_done, err;
  logic [7:0] status;

  int checks = 0;
  int passed = 0;

  // Bus model state
  typedef struct {
    logic       rw;
    logic [7:0] adr;
    logic [7:0] dat;
    int         cyc;
  } acc_t;
  acc_t       log_q[$];
  int         cyc = 0;
  int         ack_cnt = 0;
  int         rx_avail = 0, rx_reads = 0;
  int         tx_space = 0, tx_writes = 0;
  int         bus_viol = 0;
  logic [7:0] rxdr_val = 8'h00;
  logic       ack_en = 1'b1;
  logic       prev_stb, prev_ack, prev_rw;
  logic [7:0] prev_adr, prev_dati;

  always #5 clk = ~clk;

  spi_sysbus_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reinit    (reinit),
    .sb_stb    (sb_stb),
    .sb_rw     (sb_rw),
    .sb_adr    (sb_adr),
    .sb_dati   (sb_dati),
    .sb_dato   (sb_dato),
    .sb_ack    (sb_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .init_done (init_done),
    .status    (status),
    .err       (err)
  );

  assign sb_dato = (sb_adr == 8'h0C) ?
                   {3'b000, tx_space > tx_writes, rx_avail > rx_reads, 3'b000} :
                   (sb_adr == 8'h0E) ? rxdr_val : 8'h00;

  // Acks after two strobe cycles, logs completed accesses, watches bus rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_ack    <= 1'b0;
      ack_cnt   <= 0;
      prev_stb  <= 1'b0;
      prev_ack  <= 1'b0;
      prev_rw   <= 1'b0;
      prev_adr  <= 8'h00;
      prev_dati <= 8'h00;
    end else begin
      cyc       <= cyc + 1;
      prev_stb  <= sb_stb;
      prev_ack  <= sb_ack;
      prev_rw   <= sb_rw;
      prev_adr  <= sb_adr;
      prev_dati <= sb_dati;
      if (prev_stb && !prev_ack &&
          (!sb_stb || sb_adr != prev_adr || sb_rw != prev_rw || sb_dati != prev_dati))
        bus_viol <= bus_viol + 1;
      if (prev_stb && prev_ack && sb_stb) bus_viol <= bus_viol + 1;
      if (sb_ack) begin
        sb_ack  <= 1'b0;
        ack_cnt <= 0;
        if (sb_stb) begin
          log_q.push_back('{sb_rw, sb_adr, sb_dati, cyc});
          if (!sb_rw && sb_adr == 8'h0E) rx_reads <= rx_reads + 1;
          if (sb_rw && sb_adr == 8'h0D) tx_writes <= tx_writes + 1;
        end
      end else if (sb_stb && ack_en) begin
        if (ack_cnt == 1) sb_ack <= 1'b1;
        ack_cnt <= ack_cnt + 1;
      end
    end
  end

  task automatic wait_log(input int target, input int budget, output bit ok);
    int n = 0;
    while (log_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (log_q.size() >= target);
  endtask

  function automatic int count_adr(input int base, input logic [7:0] adr);
    int c = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i].adr == adr) c++;
    return c;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({sb_stb, sb_rw, tx_ready, rx_valid, init_done, err} !== 6'b0)
      $display("FAIL reset_flags: got stb/rw/txr/rxv/idone/err=%b want 000000",
               {sb_stb, sb_rw, tx_ready, rx_valid, init_done, err});
    else passed++;
    checks++;
    if ({sb_adr, sb_dati} !== 16'h0000)
      $display("FAIL reset_bus: got adr=%h dati=%h want 00 00", sb_adr, sb_dati);
    else passed++;
    checks++;
    if ({rx_data, status} !== 16'h0000)
      $display("FAIL reset_data: got rx_data=%h status=%h want 00 00", rx_data, status);
    else passed++;
  endtask

  task automatic test_init();
    logic [7:0] exp_adr [5];
    logic [7:0] exp_dat [5];
    int  base = log_q.size();
    int  n = 0;
    bit  early = 1'b0;
    bit  ok;
    exp_adr = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0F};
    exp_dat = '{8'h00, 8'h80, 8'h01, 8'h00, 8'h00};
    rst_n = 1'b1;
    while (log_q.size() < base + 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (log_q.size() < base + 5 && init_done) early = 1'b1;
    end
    checks++;
    if (log_q.size() < base + 5) begin
      $display("FAIL init_count: got %0d accesses want 5", log_q.size() - base);
    end else begin
      passed++;
      for (int i = 0; i < 5; i++) begin
        checks++;
        if ({log_q[base+i].rw, log_q[base+i].adr, log_q[base+i].dat} !==
            {1'b1, exp_adr[i], exp_dat[i]})
          $display("FAIL init_wr%0d: got rw=%b adr=%h dat=%h want 1 %h %h", i,
                   log_q[base+i].rw, log_q[base+i].adr, log_q[base+i].dat,
                   exp_adr[i], exp_dat[i]);
        else passed++;
      end
    end
    checks++;
    if (early || init_done !== 1'b1)
      $display("FAIL init_done: got early=%b now=%b want early=0 now=1", early, init_done);
    else passed++;
    wait_log(base + 8, 60, ok);
    checks++;
    if (!ok || count_adr(base + 5, 8'h0C) != 3 || log_q[base+5].rw !== 1'b0)
      $display("FAIL init_poll: got %0d SR reads want 3", count_adr(base + 5, 8'h0C));
    else passed++;
  endtask

  task automatic test_rx();
    int base = log_q.size();
    int n = 0;
    rx_ready = 1'b1;
    rxdr_val = 8'hA5;
    rx_avail++;
    while (!rx_valid && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA5)
      $display("FAIL rx_data: got valid=%b data=%h want 1 a5", rx_valid, rx_data);
    else passed++;
    checks++;
    if (status !== 8'h08) $display("FAIL rx_status: got %h want 08", status);
    else passed++;
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) $display("FAIL rx_clear: got rx_valid=%b want 0", rx_valid);
    else passed++;
    repeat (20) @(negedge clk);
    checks++;
    if (count_adr(base, 8'h0E) != 1)
      $display("FAIL rx_once: got %0d RXDR reads want 1", count_adr(base, 8'h0E));
    else passed++;
  endtask

  task automatic test_tx();
    int n = 0;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    tx_space++;
    while (!tx_ready && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (tx_ready !== 1'b1 || log_q.size() == 0 ||
        {log_q[$].rw, log_q[$].adr, log_q[$].dat} !== {1'b1, 8'h0D, 8'h3C})
      $display("FAIL tx_write: got tx_ready=%b last rw=%b adr=%h dat=%h want 1 1 0d 3c",
               tx_ready, log_q[$].rw, log_q[$].adr, log_q[$].dat);
    else passed++;
    checks++;
    if (cyc != log_q[$].cyc + 1)
      $display("FAIL tx_ready_lat: got %0d cycles after ack want 1", cyc - log_q[$].cyc);
    else passed++;
    tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b0) $display("FAIL tx_pulse: got tx_ready=%b want 0", tx_ready);
    else passed++;
  endtask

  task automatic test_tx_drop();
    int n = 0;
    tx_data  = 8'h6E;
    tx_valid = 1'b1;
    tx_space++;
    while (!(sb_stb && sb_adr == 8'h0D) && n < 60) begin @(negedge clk); n++; end
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    n = 0;
    while (!tx_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (tx_ready !== 1'b1 || log_q[$].adr !== 8'h0D || log_q[$].dat !== 8'h6E)
      $display("FAIL tx_drop: got tx_ready=%b adr=%h dat=%h want 1 0d 6e",
               tx_ready, log_q[$].adr, log_q[$].dat);
    else passed++;
  endtask

  task automatic test_priority();
    int base = log_q.size();
    int irx = -1, itx = -1;
    int n = 0;
    rx_ready = 1'b1;
    rxdr_val = 8'h11;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    rx_avail++;
    tx_space++;
    while (count_adr(base, 8'h0D) == 0 && n < 80) begin @(negedge clk); n++; end
    tx_valid = 1'b0;
    for (int i = log_q.size() - 1; i >= base; i--) begin
      if (log_q[i].adr == 8'h0E) irx = i;
      if (log_q[i].adr == 8'h0D) itx = i;
    end
    checks++;
    if (irx < 0 || itx < 0 || irx > itx)
      $display("FAIL prio_order: got rxdr idx=%0d txdr idx=%0d want rxdr first", irx, itx);
    else passed++;
    checks++;
    if (rx_data !== 8'h11) $display("FAIL prio_rxdata: got %h want 11", rx_data);
    else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int base;
    int n = 0;
    rx_ready = 1'b0;
    rxdr_val = 8'h77;
    rx_avail++;
    while (!rx_valid && n < 60) begin @(negedge clk); n++; end
    rxdr_val = 8'h78;
    rx_avail++;
    base = log_q.size();
    repeat (30) @(negedge clk);
    checks++;
    if (count_adr(base, 8'h0E) != 0)
      $display("FAIL bp_noread: got %0d RXDR reads want 0", count_adr(base, 8'h0E));
    else passed++;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h77 || status !== 8'h08)
      $display("FAIL bp_hold: got valid=%b data=%h status=%h want 1 77 08",
               rx_valid, rx_data, status);
    else passed++;
    rx_ready = 1'b1;
    n = 0;
    while (!(rx_valid && rx_data == 8'h78) && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (rx_data !== 8'h78 || count_adr(base, 8'h0E) != 1)
      $display("FAIL bp_resume: got data=%h reads=%0d want 78 1",
               rx_data, count_adr(base, 8'h0E));
    else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reinit();
    logic [39:0] got = '0;
    int base, nwr = 0;
    int n = 0;
    rx_ready = 1'b0;
    rxdr_val = 8'h42;
    rx_avail++;
    while (!rx_valid && n < 60) begin @(negedge clk); n++; end
    base = log_q.size();
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    n = 0;
    while (init_done && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (init_done !== 1'b0) $display("FAIL reinit_clear: got init_done=%b want 0", init_done);
    else passed++;
    n = 0;
    while (!init_done && n < 100) begin @(negedge clk); n++; end
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i].rw) begin got = {got[31:0], log_q[i].adr}; nwr++; end
    checks++;
    if (nwr != 5 || got !== 40'h08090A0B0F)
      $display("FAIL reinit_seq: got %0d writes %h want 5 08090a0b0f", nwr, got);
    else passed++;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h42)
      $display("FAIL reinit_rx: got valid=%b data=%h want 1 42", rx_valid, rx_data);
    else passed++;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int base;
    int n = 0;
    bit ok;
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    tx_space++;
    while (!(sb_stb && sb_adr == 8'h0D) && n < 60) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sb_stb !== 1'b0 || init_done !== 1'b0)
      $display("FAIL rst_mid: got stb=%b init_done=%b want 0 0", sb_stb, init_done);
    else passed++;
    tx_valid = 1'b0;
    tx_space = tx_writes;
    repeat (2) @(negedge clk);
    base = log_q.size();
    rst_n = 1'b1;
    wait_log(base + 1, 40, ok);
    checks++;
    if (!ok || {log_q[base].rw, log_q[base].adr, log_q[base].dat} !== {1'b1, 8'h08, 8'h00})
      $display("FAIL rst_restart: got first rw=%b adr=%h want 1 08",
               log_q[base].rw, log_q[base].adr);
    else passed++;
    repeat (30) @(negedge clk);
  endtask

`ifdef SPI_SYSBUS_TIMEOUT_EN
  task automatic test_timeout();
    int base;
    int n = 0;
    bit ok;
    ack_en = 1'b0;
    while (!err && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (err !== 1'b1 || sb_stb !== 1'b0)
      $display("FAIL timeout: got err=%b stb=%b want 1 0", err, sb_stb);
    else passed++;
    base = log_q.size();
    ack_en = 1'b1;
    wait_log(base + 1, 400, ok);
    checks++;
    if (!ok || log_q[base].adr !== 8'h08)
      $display("FAIL timeout_restart: got adr=%h want 08", log_q[base].adr);
    else passed++;
  endtask
`endif

  task automatic test_bus_rules();
    checks++;
    if (bus_viol != 0) $display("FAIL bus_rules: got %0d violations want 0", bus_viol);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_rx();
    test_tx();
    test_tx_drop();
    test_priority();
    test_backpressure();
    test_reinit();
    test_bus_rules();
    test_reset_mid();
`ifdef SPI_SYSBUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule
